// File: rtl/frame_check_pkg.sv
// Shared types for the frame checker: parity modes, FSM states and cfg decode.
package frame_check_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_STOP1 = 2'b01,
      ST_STOP2 = 2'b10
   } state_e;

   // Map the raw 2-bit configuration to a parity mode; 2'b11 behaves as NONE.
   function automatic parity_mode_e decode_parity(input logic [1:0] cfg);
      case (cfg)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity check of one received frame's data and parity bit.
module parity_calc
   import frame_check_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_parity,
   input  parity_mode_e      i_mode,
   output logic              o_err_c
);

   logic w_xor;

   assign w_xor = ^{i_data, i_parity};

   // EVEN expects an even total count of ones, ODD an odd count.
   always_comb begin
      o_err_c = 1'b0;
      case (i_mode)
         PAR_EVEN: o_err_c = w_xor;
         PAR_ODD:  o_err_c = ~w_xor;
         default:  o_err_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/frame_check.sv
// Frame checker: evaluates parity and stop bits of received frames, latches
// error flags, pulses check_done on completion and counts errored frames.
// Optional feature macro: FRAME_CHECK_ERR_CNT_EN builds the saturating
// error counter; without it err_count is constant zero.
module frame_check
   import frame_check_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              fc_clear,
   input  logic              data_load,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_parity,
   input  logic              stop_strobe,
   input  logic              stop_bit,
   input  logic [1:0]        cfg_parity,
   input  logic              cfg_two_stop,
   output logic              framing_error,
   output logic              parity_error,
   output logic              check_done,
   output logic [CNT_W-1:0]  err_count
);

   state_e r_state;
   state_e w_state_nxt;

   // Per-frame accumulators; the parity mode is folded into r_par_acc at load.
   logic r_frm_acc, w_frm_acc_nxt;
   logic r_par_acc, w_par_acc_nxt;
   logic r_two_stop, w_two_stop_nxt;

   logic r_frm_err, w_frm_err_nxt;
   logic r_par_err, w_par_err_nxt;
   logic r_done, w_done_nxt;

   logic w_complete;
   logic w_frm_fin;
   logic w_par_err_c;

   parity_calc #(
      .DATA_W (DATA_W)
   ) u_parity_calc (
      .i_data   (rx_data),
      .i_parity (rx_parity),
      .i_mode   (decode_parity(cfg_parity)),
      .o_err_c  (w_par_err_c)
   );

   // Next-state and next-output logic; clear beats load, load beats strobe.
   always_comb begin
      w_state_nxt    = r_state;
      w_frm_acc_nxt  = r_frm_acc;
      w_par_acc_nxt  = r_par_acc;
      w_two_stop_nxt = r_two_stop;
      w_frm_err_nxt  = r_frm_err;
      w_par_err_nxt  = r_par_err;
      w_done_nxt     = 1'b0;
      w_complete     = 1'b0;
      w_frm_fin      = 1'b0;

      if (fc_clear) begin
         w_state_nxt    = ST_IDLE;
         w_frm_acc_nxt  = 1'b0;
         w_par_acc_nxt  = 1'b0;
         w_two_stop_nxt = 1'b0;
         w_frm_err_nxt  = 1'b0;
         w_par_err_nxt  = 1'b0;
      end else if (data_load) begin
         // Starts a frame from IDLE, or aborts and restarts one in progress.
         w_state_nxt    = ST_STOP1;
         w_frm_acc_nxt  = 1'b0;
         w_par_acc_nxt  = w_par_err_c;
         w_two_stop_nxt = cfg_two_stop;
      end else if (stop_strobe) begin
         case (r_state)
            ST_STOP1: begin
               w_frm_acc_nxt = ~stop_bit;
               if (r_two_stop) begin
                  w_state_nxt = ST_STOP2;
               end else begin
                  w_complete = 1'b1;
                  w_frm_fin  = ~stop_bit;
               end
            end
            ST_STOP2: begin
               w_complete = 1'b1;
               w_frm_fin  = r_frm_acc | ~stop_bit;
            end
            default: ;
         endcase
      end

      if (w_complete) begin
         w_state_nxt   = ST_IDLE;
         w_frm_acc_nxt = w_frm_fin;
         w_frm_err_nxt = w_frm_fin;
         w_par_err_nxt = r_par_acc;
         w_done_nxt    = 1'b1;
      end
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state    <= ST_IDLE;
         r_frm_acc  <= 1'b0;
         r_par_acc  <= 1'b0;
         r_two_stop <= 1'b0;
         r_frm_err  <= 1'b0;
         r_par_err  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_frm_acc  <= w_frm_acc_nxt;
         r_par_acc  <= w_par_acc_nxt;
         r_two_stop <= w_two_stop_nxt;
         r_frm_err  <= w_frm_err_nxt;
         r_par_err  <= w_par_err_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign framing_error = r_frm_err;
   assign parity_error  = r_par_err;
   assign check_done    = r_done;

`ifdef FRAME_CHECK_ERR_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_err_cnt;

   // Saturating count of completed frames carrying any error.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_err_cnt <= '0;
      end else if (fc_clear) begin
         r_err_cnt <= '0;
      end else if (w_complete && (w_frm_fin || r_par_acc) && (r_err_cnt != CNT_MAX)) begin
         r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign err_count = r_err_cnt;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_frame_check.sv
// Scoreboard bench for frame_check: stimulus pushes expected completions,
// a negedge monitor pops and compares whenever check_done is seen.
module tb_frame_check;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 2;
`ifdef FRAME_CHECK_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct packed {
      logic             frm;
      logic             par;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              fc_clear;
   logic              data_load;
   logic [DATA_W-1:0] rx_data;
   logic              rx_parity;
   logic              stop_strobe;
   logic              stop_bit;
   logic [1:0]        cfg_parity;
   logic              cfg_two_stop;
   logic              framing_error;
   logic              parity_error;
   logic              check_done;
   logic [CNT_W-1:0]  err_count;

   exp_t              q[$];
   logic [CNT_W-1:0]  exp_cnt = '0;
   int                n_vec  = 0;
   int                n_miss = 0;

   frame_check #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .fc_clear      (fc_clear),
      .data_load     (data_load),
      .rx_data       (rx_data),
      .rx_parity     (rx_parity),
      .stop_strobe   (stop_strobe),
      .stop_bit      (stop_bit),
      .cfg_parity    (cfg_parity),
      .cfg_two_stop  (cfg_two_stop),
      .framing_error (framing_error),
      .parity_error  (parity_error),
      .check_done    (check_done),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every check_done must match the oldest expected completion.
   always @(negedge clk) begin
      if (n_rst && check_done) begin
         exp_t e;
         if (q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_done: check_done=1 with no frame expected at %0t", $time);
         end else begin
            e = q.pop_front();
            chk("done_framing", int'(framing_error), int'(e.frm));
            chk("done_parity", int'(parity_error), int'(e.par));
            chk("done_count", int'(err_count), int'(e.cnt));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] pm, input logic two, input logic [7:0] d, input logic p);
      cfg_parity   = pm;
      cfg_two_stop = two;
      rx_data      = d;
      rx_parity    = p;
      data_load    = 1'b1;
      tick();
      data_load    = 1'b0;
   endtask

   task automatic strobe(input logic b);
      stop_strobe = 1'b1;
      stop_bit    = b;
      tick();
      stop_strobe = 1'b0;
   endtask

   task automatic expect_frame(input logic frm, input logic par);
      exp_t e;
      if (CNT_EN && (frm || par) && exp_cnt != '1) exp_cnt = exp_cnt + CNT_W'(1);
      e.frm = frm;
      e.par = par;
      e.cnt = exp_cnt;
      q.push_back(e);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_framing"}, int'(framing_error), 0);
      chk({tag, "_parity"}, int'(parity_error), 0);
      chk({tag, "_done"}, int'(check_done), 0);
      chk({tag, "_count"}, int'(err_count), 0);
   endtask

   initial begin
      n_rst = 1'b0; fc_clear = 1'b0; data_load = 1'b0; rx_data = '0; rx_parity = 1'b0;
      stop_strobe = 1'b0; stop_bit = 1'b1; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
      tick(); tick();
      chk_all_zero("reset");
      n_rst = 1'b1;
      tick();

      // EVEN, A5 has four ones, parity 0: clean frame.
      load(2'b01, 1'b0, 8'hA5, 1'b0);
      tick();
      expect_frame(1'b0, 1'b0);
      strobe(1'b1);
      chk("done_pulse_one_cycle", int'(check_done), 1);
      tick();
      chk("done_pulse_drops", int'(check_done), 0);

      // ODD, 01 with parity 1 gives even ones: parity error.
      load(2'b10, 1'b0, 8'h01, 1'b1);
      expect_frame(1'b0, 1'b1);
      strobe(1'b1);
      tick(); tick(); tick();
      chk("hold_parity", int'(parity_error), 1);
      chk("hold_framing", int'(framing_error), 0);

      // Two stops, second one bad: no completion after first strobe.
      load(2'b01, 1'b1, 8'h03, 1'b0);
      strobe(1'b1);
      chk("two_stop_no_early_done", int'(check_done), 0);
      tick();
      expect_frame(1'b1, 1'b0);
      strobe(1'b0);
      tick();

      // Abort in STOP1: errored frame replaced by a clean one.
      load(2'b01, 1'b0, 8'h01, 1'b0);
      tick();
      load(2'b01, 1'b0, 8'h01, 1'b1);
      expect_frame(1'b0, 1'b0);
      strobe(1'b1);
      tick();

      // Configuration change mid-frame is ignored.
      load(2'b01, 1'b0, 8'h07, 1'b1);
      cfg_parity = 2'b10; cfg_two_stop = 1'b1;
      tick();
      expect_frame(1'b0, 1'b0);
      strobe(1'b1);
      tick();

      // Parity mode 11 acts as NONE; bad stop bit.
      load(2'b11, 1'b0, 8'h01, 1'b0);
      expect_frame(1'b1, 1'b0);
      strobe(1'b0);
      tick();

      // Load and strobe together: load wins, strobe ignored.
      load(2'b01, 1'b0, 8'hA5, 1'b0);
      stop_strobe = 1'b1; stop_bit = 1'b1;
      load(2'b01, 1'b0, 8'hFF, 1'b1);
      stop_strobe = 1'b0;
      chk("load_beats_strobe", int'(check_done), 0);
      tick();
      expect_frame(1'b0, 1'b1);
      strobe(1'b1);
      tick();

      // Fifth errored frame: both errors, counter saturated.
      load(2'b10, 1'b0, 8'h03, 1'b0);
      expect_frame(1'b1, 1'b1);
      strobe(1'b0);
      tick();
      chk("sat_count", int'(err_count), CNT_EN ? 3 : 0);

      // Reset mid-STOP2 discards the frame.
      load(2'b01, 1'b1, 8'h00, 1'b0);
      strobe(1'b1);
      n_rst = 1'b0;
      tick();
      exp_cnt = '0;
      chk_all_zero("reset_mid_frame");
      n_rst = 1'b1;
      strobe(1'b1);
      chk("reset_no_done", int'(check_done), 0);
      tick();

      // Errored frame, then clear.
      load(2'b10, 1'b0, 8'h00, 1'b0);
      expect_frame(1'b1, 1'b1);
      strobe(1'b0);
      tick();
      fc_clear = 1'b1;
      tick();
      fc_clear = 1'b0;
      exp_cnt = '0;
      chk_all_zero("clear");

      // Clear mid-frame and clear with load both drop the frame.
      load(2'b01, 1'b0, 8'h01, 1'b0);
      fc_clear = 1'b1;
      tick();
      fc_clear = 1'b0;
      strobe(1'b1);
      chk("clear_mid_no_done", int'(check_done), 0);
      fc_clear = 1'b1;
      load(2'b01, 1'b0, 8'h01, 1'b0);
      fc_clear = 1'b0;
      strobe(1'b0);
      chk("clear_beats_load", int'(check_done), 0);
      tick(); tick();
      chk_all_zero("final");

      chk("pending_expected", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/frame_check.md
FRAME_CHECK -- requirements
Module: frame_check

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning received data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning error-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port fc_clear, input, 1 bit: synchronous clear of flags, FSM and counter.
REQ-006 The block SHALL have port data_load, input, 1 bit: one-cycle strobe that a frame's data and parity are valid.
REQ-007 The block SHALL have port rx_data, input, DATA_W bits: received data bits.
REQ-008 The block SHALL have port rx_parity, input, 1 bit: received parity bit, ignored when parity mode is NONE.
REQ-009 The block SHALL have port stop_strobe, input, 1 bit: one-cycle strobe that stop_bit is sampled.
REQ-010 The block SHALL have port stop_bit, input, 1 bit: sampled stop-bit line value.
REQ-011 The block SHALL have port cfg_parity, input, 2 bits: 00 NONE, 01 EVEN, 10 ODD, 11 treated as NONE.
REQ-012 The block SHALL have port cfg_two_stop, input, 1 bit: 1 means two stop bits are expected.
REQ-013 The block SHALL have port framing_error, output, 1 bit: latched framing error of the last completed frame.
REQ-014 The block SHALL have port parity_error, output, 1 bit: latched parity error of the last completed frame.
REQ-015 The block SHALL have port check_done, output, 1 bit: one-cycle pulse when a frame's check completes.
REQ-016 The block SHALL have port err_count, output, CNT_W bits: saturating count of frames with any error.

Function
REQ-017 The FSM SHALL have states IDLE, STOP1 and STOP2.
REQ-018 In IDLE, data_load SHALL capture the parity result, sample cfg_parity and cfg_two_stop, and move to STOP1; stop_strobe in IDLE SHALL be ignored.
REQ-019 The parity result SHALL be: EVEN error when XOR(rx_data, rx_parity)=1; ODD error when XOR(rx_data, rx_parity)=0; NONE gives no error.
REQ-020 In STOP1, stop_strobe SHALL record a framing error if stop_bit=0, then go to STOP2 if two stops were sampled, otherwise complete.
REQ-021 In STOP2, stop_strobe SHALL OR a framing error in if stop_bit=0, then complete.
REQ-022 On completion: framing_error and parity_error SHALL update in the same cycle, check_done SHALL be 1 for exactly the next cycle, and the FSM SHALL return to IDLE.
REQ-023 Latency from the final stop_strobe edge to valid flags and check_done SHALL be one clock.
REQ-024 framing_error and parity_error SHALL hold their values until the next completion or clear.
REQ-025 err_count SHALL increment by 1 on a completion with any error, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-026 data_load in STOP1 or STOP2 SHALL abort the frame in progress: no completion, no count, and a restart to STOP1 with the new data.
REQ-027 When data_load and stop_strobe are asserted together, data_load SHALL take priority and stop_strobe SHALL be ignored.
REQ-028 fc_clear SHALL override all other inputs in the same cycle: flags 0, count 0, check_done 0, FSM to IDLE.
REQ-029 Configuration inputs changing mid-frame SHALL NOT affect that frame.

Reset
REQ-030 While n_rst=0 at a rising clk edge: FSM IDLE, framing_error 0, parity_error 0, check_done 0, err_count 0.
REQ-031 Reset SHALL take priority over fc_clear, and reset mid-frame SHALL discard the frame.

Configuration
REQ-032 With FRAME_CHECK_ERR_CNT_EN defined, the counter SHALL be built per REQ-025; without it, err_count SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-033 The shared package frame_check_pkg SHALL hold the parity-mode enum (NONE/EVEN/ODD) and the FSM state enum.
REQ-034 Parity computation SHALL be a sub-module named parity_calc, parameterised by DATA_W.

Verification
REQ-035 Test: EVEN, DATA_W=8, one stop; rx_data=8'hA5, rx_parity=0, stop_bit=1 -> check_done pulse, both flags 0, count unchanged.
REQ-036 Test: ODD, rx_data=8'h01, rx_parity=1, stop_bit=1 -> parity_error=1, framing_error=0, count +1.
REQ-037 Test: two stops, first stop 1 and second stop 0 -> framing_error=1 after the second strobe only, with no check_done after the first strobe.
REQ-038 Test: data_load during STOP1 -> no check_done for the aborted frame, and the new frame completes normally.
REQ-039 Test: CNT_W=2 with 5 errored frames -> err_count=3; then fc_clear -> 0 and both flags 0.
REQ-040 Test: n_rst=0 mid-STOP2 -> all outputs 0, and the following stop_strobe gives no check_done.
